// File: rtl/ram_mmio_pkg.sv
// Shared defaults, address map constants and range-check helpers for ram_mmio_dc.
package ram_mmio_pkg;

    localparam int unsigned DEF_WIDTH       = 16;
    localparam int unsigned DEF_AW          = 8;
    localparam int unsigned DEF_DEPTH       = 8;
    localparam int unsigned DEF_N_IN        = 1;
    localparam int unsigned DEF_N_OUT       = 1;
    localparam int unsigned DEF_IO_IN_BASE  = 32'h40;
    localparam int unsigned DEF_IO_OUT_BASE = 32'h44;
    localparam logic [DEF_WIDTH-1:0] DEF_DEFAULT_RD = 16'hFFFF;

    // True when [a_base, a_base+a_n) and [b_base, b_base+b_n) share any address.
    function automatic bit ranges_overlap(input int unsigned a_base, input int unsigned a_n,
                                          input int unsigned b_base, input int unsigned b_n);
        return (a_base < b_base + b_n) && (b_base < a_base + a_n);
    endfunction

    // True when [base, base+n) lies entirely inside an aw-bit address space.
    function automatic bit range_fits(input int unsigned base, input int unsigned n,
                                      input int unsigned aw);
        longint unsigned lim;
        lim = longint'(64'd1) << aw;
        return (longint'(base) + longint'(n)) <= lim;
    endfunction

endpackage

// File: rtl/ram_mmio_dc_io_in_sync.sv
// One asynchronous input channel: 2-flop synchroniser, previous-value register
// and a sticky change flag whose set has priority over the read-clear.
module io_in_sync #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] sync_o,
    output logic             chg_o,
    output logic             chg_nxt_c_o
);

    logic [WIDTH-1:0] s1_q, s2_q, prev_q;
    logic [2:0]       vld_q;
    logic             chg_q, chg_d;
    logic             set_c;

    // Change detection only once prev holds a real post-reset sample, so the
    // first sample after reset never looks like an edge against the reset zero.
    always_comb begin
        set_c = vld_q[2] && (s2_q != prev_q);
        chg_d = chg_q;
        if (clr_i) chg_d = 1'b0;
        if (set_c) chg_d = 1'b1;
    end

    // Synchroniser, history register, pipeline-fill tracker and sticky flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
            vld_q  <= '0;
            chg_q  <= 1'b0;
        end else begin
            s1_q   <= din_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            vld_q  <= {vld_q[1:0], 1'b1};
            chg_q  <= chg_d;
        end
    end

    assign sync_o      = s2_q;
    assign chg_o       = chg_q;
    assign chg_nxt_c_o = chg_d;

endmodule

// File: rtl/ram_mmio_dc.sv
// Data memory plus memory-mapped I/O decoder: registered read, synchronous
// write, synchronised input ports with change flags, writable output latches.
module ram_mmio_dc
    import ram_mmio_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEF_WIDTH,
    parameter int unsigned      AW          = DEF_AW,
    parameter int unsigned      DEPTH       = DEF_DEPTH,
    parameter int unsigned      N_IN        = DEF_N_IN,
    parameter int unsigned      N_OUT       = DEF_N_OUT,
    parameter int unsigned      IO_IN_BASE  = DEF_IO_IN_BASE,
    parameter int unsigned      IO_OUT_BASE = DEF_IO_OUT_BASE,
    parameter logic [WIDTH-1:0] DEFAULT_RD  = WIDTH'(DEF_DEFAULT_RD)
) (
    input  logic                   CLK_DC,
    input  logic                   RESET,
    input  logic [AW-1:0]          RAM_AD_IN,
    input  logic                   RAM_WE,
    input  logic [WIDTH-1:0]       RAM_IN,
    input  logic [N_IN*WIDTH-1:0]  IO_IN,
    output logic [AW-1:0]          RAM_AD_OUT,
    output logic [WIDTH-1:0]       RAM_OUT,
    output logic [N_OUT*WIDTH-1:0] IO_OUT,
    output logic [N_IN-1:0]        IO_CHG,
    output logic                   IO_IRQ
);

    // Address-map sanity checks at elaboration.
    if (DEPTH > IO_IN_BASE) begin : g_chk_depth
        $error("ram_mmio_dc: DEPTH overlaps the input-port range");
    end
    if (ranges_overlap(IO_IN_BASE, N_IN, IO_OUT_BASE, N_OUT)) begin : g_chk_overlap
        $error("ram_mmio_dc: input-port and output-latch ranges overlap");
    end
    if (!range_fits(IO_IN_BASE, N_IN, AW) || !range_fits(IO_OUT_BASE, N_OUT, AW)) begin : g_chk_fit
        $error("ram_mmio_dc: I/O range exceeds the address space");
    end

    logic [WIDTH-1:0]      ram_q [DEPTH];
    logic [WIDTH-1:0]      ram_d [DEPTH];
    logic [WIDTH-1:0]      out_q [N_OUT];
    logic [WIDTH-1:0]      out_d [N_OUT];
    logic [AW-1:0]         ad_out_q;
    logic [WIDTH-1:0]      rd_q;
    logic [WIDTH-1:0]      rd_data_c;
    logic                  irq_q;
    logic [N_IN*WIDTH-1:0] in_sync;
    logic [N_IN-1:0]       chg_nxt;

    // Per-channel input synchronisers; a non-write access to the channel clears its flag.
    for (genvar k = 0; k < int'(N_IN); k++) begin : g_in
        io_in_sync #(
            .WIDTH (WIDTH)
        ) u_sync (
            .clk_i       (CLK_DC),
            .rst_i       (RESET),
            .din_i       (IO_IN[k*WIDTH +: WIDTH]),
            .clr_i       (!RAM_WE && (RAM_AD_IN == AW'(IO_IN_BASE + k))),
            .sync_o      (in_sync[k*WIDTH +: WIDTH]),
            .chg_o       (IO_CHG[k]),
            .chg_nxt_c_o (chg_nxt[k])
        );
    end

    // Read decode: exact AW-bit compares, anything unmatched returns DEFAULT_RD.
    always_comb begin
        rd_data_c = DEFAULT_RD;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (RAM_AD_IN == AW'(k)) rd_data_c = ram_q[k];
        end
        for (int k = 0; k < int'(N_IN); k++) begin
            if (RAM_AD_IN == AW'(IO_IN_BASE + k)) rd_data_c = in_sync[k*WIDTH +: WIDTH];
        end
        for (int k = 0; k < int'(N_OUT); k++) begin
            if (RAM_AD_IN == AW'(IO_OUT_BASE + k)) rd_data_c = out_q[k];
        end
    end

    // Write decode: RAM words and output latches only; input ports are read-only.
    always_comb begin
        ram_d = ram_q;
        out_d = out_q;
        if (RAM_WE) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (RAM_AD_IN == AW'(k)) ram_d[k] = RAM_IN;
            end
            for (int k = 0; k < int'(N_OUT); k++) begin
                if (RAM_AD_IN == AW'(IO_OUT_BASE + k)) out_d[k] = RAM_IN;
            end
        end
    end

    // Storage and read-port registers; reads sample pre-write contents (read-first).
    always_ff @(posedge CLK_DC or posedge RESET) begin
        if (RESET) begin
            ram_q    <= '{default: '0};
            out_q    <= '{default: '0};
            ad_out_q <= '0;
            rd_q     <= '0;
            irq_q    <= 1'b0;
        end else begin
            ram_q    <= ram_d;
            out_q    <= out_d;
            ad_out_q <= RAM_AD_IN;
            rd_q     <= rd_data_c;
            irq_q    <= |chg_nxt;
        end
    end

    // Flatten output latches onto the packed port.
    for (genvar k = 0; k < int'(N_OUT); k++) begin : g_out
        assign IO_OUT[k*WIDTH +: WIDTH] = out_q[k];
    end

    assign RAM_AD_OUT = ad_out_q;
    assign RAM_OUT    = rd_q;
    assign IO_IRQ     = irq_q;

endmodule
